// File: rtl/xy_route_demux_if.sv
// Link-side and FIFO-side signal bundle of the XY route demultiplexer.
// The slave modport is taken by the router; the master modport by whatever drives the link.
interface xy_route_demux_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [4:0] fifo_read;
    logic [4:0] write;
    logic [7:0] data_out;
    logic       busy;
    logic       route_err;

    modport master (
        output in_valid, in_data, fifo_read,
        input  in_ready, write, data_out, busy, route_err
    );

    modport slave (
        input  in_valid, in_data, fifo_read,
        output in_ready, write, data_out, busy, route_err
    );
endinterface

// File: rtl/xy_route_demux.sv
// Input-port XY router front end: decodes the header flit, picks one output FIFO and steers the packet into it under per-output credit control.
// Optional feature macro ROUTE_ERR_EN: drop packets whose destination lies outside the mesh and pulse route_err.
module xy_route_demux #(
    parameter logic [1:0] LOCAL_X    = 2'd0,
    parameter logic [1:0] LOCAL_Y    = 2'd0,
    parameter int         MESH_X     = 4,
    parameter int         MESH_Y     = 4,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    xy_route_demux_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROUTE = 3'd1,
        ST_HDR   = 3'd2,
        ST_BODY  = 3'd3
`ifdef ROUTE_ERR_EN
        , ST_DROP = 3'd4
`endif
    } state_t;

    localparam logic [3:0] CREDIT_INIT = 4'(FIFO_DEPTH);

    state_t     state_r, state_s;
    logic [7:0] hdr_r, hdr_s;
    logic [2:0] port_r, port_s;
    logic [3:0] remaining_r, remaining_s;
    logic [4:0] write_r, write_s;
    logic [7:0] data_r, data_s;
    logic       ready_r, ready_s;
    logic       busy_r, busy_s;
    logic [3:0] credit_r [5];
    logic [3:0] credit_s [5];

    // Port index 0=local 1=north 2=east 3=south 4=west; X is resolved before Y.
    function automatic logic [2:0] xy_port(input logic [1:0] dx, input logic [1:0] dy);
        if (dx > LOCAL_X) begin
            xy_port = 3'd2;
        end else if (dx < LOCAL_X) begin
            xy_port = 3'd4;
        end else if (dy > LOCAL_Y) begin
            xy_port = 3'd3;
        end else if (dy < LOCAL_Y) begin
            xy_port = 3'd1;
        end else begin
            xy_port = 3'd0;
        end
    endfunction

    function automatic logic [4:0] port_onehot(input logic [2:0] p);
        case (p)
            3'd0:    port_onehot = 5'b00001;
            3'd1:    port_onehot = 5'b00010;
            3'd2:    port_onehot = 5'b00100;
            3'd3:    port_onehot = 5'b01000;
            3'd4:    port_onehot = 5'b10000;
            default: port_onehot = 5'b00000;
        endcase
    endfunction

`ifdef ROUTE_ERR_EN
    logic route_err_r, route_err_s;

    function automatic logic dest_invalid(input logic [1:0] dx, input logic [1:0] dy);
        dest_invalid = ({30'd0, dx} >= 32'(MESH_X)) || ({30'd0, dy} >= 32'(MESH_Y));
    endfunction
`else
    logic unused_mesh_s;
    assign unused_mesh_s = (MESH_X > 0) ^ (MESH_Y > 0);
`endif

    // Next-state, header capture, route selection and write strobe generation.
    always_comb begin
        state_s     = state_r;
        hdr_s       = hdr_r;
        port_s      = port_r;
        remaining_s = remaining_r;
        write_s     = 5'b00000;
        data_s      = 8'h00;
`ifdef ROUTE_ERR_EN
        route_err_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && ready_r) begin
                    hdr_s   = bus.in_data;
                    state_s = ST_ROUTE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                port_s = xy_port(hdr_r[7:6], hdr_r[5:4]);
`ifdef ROUTE_ERR_EN
                if (dest_invalid(hdr_r[7:6], hdr_r[5:4])) begin
                    state_s     = ST_DROP;
                    remaining_s = hdr_r[3:0];
                    route_err_s = 1'b1;
                end else begin
                    state_s = ST_HDR;
                end
`else
                state_s = ST_HDR;
`endif
            end
            ST_HDR: begin
                if (credit_r[port_r] != 4'd0) begin
                    write_s     = port_onehot(port_r);
                    data_s      = hdr_r;
                    remaining_s = hdr_r[3:0];
                    state_s     = (hdr_r[3:0] == 4'd0) ? ST_IDLE : ST_BODY;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_BODY: begin
                // ready_r already encodes credit[port_r] > 0 for this cycle.
                if (bus.in_valid && ready_r) begin
                    write_s     = port_onehot(port_r);
                    data_s      = bus.in_data;
                    remaining_s = remaining_r - 4'd1;
                    state_s     = (remaining_r == 4'd1) ? ST_IDLE : ST_BODY;
                end else begin
                    state_s = ST_BODY;
                end
            end
`ifdef ROUTE_ERR_EN
            ST_DROP: begin
                if (remaining_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else if (bus.in_valid && ready_r) begin
                    remaining_s = remaining_r - 4'd1;
                    state_s     = (remaining_r == 4'd1) ? ST_IDLE : ST_DROP;
                end else begin
                    state_s = ST_DROP;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Credit bookkeeping: a write and a read on the same port cancel out.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            if (write_s[i] && !bus.fifo_read[i]) begin
                credit_s[i] = (credit_r[i] != 4'd0) ? credit_r[i] - 4'd1 : credit_r[i];
            end else if (!write_s[i] && bus.fifo_read[i]) begin
                credit_s[i] = (credit_r[i] < CREDIT_INIT) ? credit_r[i] + 4'd1 : credit_r[i];
            end else begin
                credit_s[i] = credit_r[i];
            end
        end
    end

    // in_ready and busy are registered, so they are computed from next state and next credit.
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        case (state_s)
            ST_IDLE: ready_s = 1'b1;
            ST_BODY: ready_s = (credit_s[port_s] != 4'd0);
`ifdef ROUTE_ERR_EN
            ST_DROP: ready_s = 1'b1;
`endif
            default: ready_s = 1'b0;
        endcase
    end

    // State, datapath and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hdr_r       <= 8'h00;
            port_r      <= 3'd0;
            remaining_r <= 4'd0;
            write_r     <= 5'b00000;
            data_r      <= 8'h00;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                credit_r[i] <= CREDIT_INIT;
            end
        end else begin
            state_r     <= state_s;
            hdr_r       <= hdr_s;
            port_r      <= port_s;
            remaining_r <= remaining_s;
            write_r     <= write_s;
            data_r      <= data_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            for (int i = 0; i < 5; i++) begin
                credit_r[i] <= credit_s[i];
            end
        end
    end

`ifdef ROUTE_ERR_EN
    // One-cycle drop indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_err_r <= 1'b0;
        end else begin
            route_err_r <= route_err_s;
        end
    end

    assign bus.route_err = route_err_r;
`else
    assign bus.route_err = 1'b0;
`endif

    assign bus.in_ready = ready_r;
    assign bus.write    = write_r;
    assign bus.data_out = data_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_xy_route_demux.sv
// Directed self-checking bench for xy_route_demux at LOCAL=(1,1); runs the drop test when ROUTE_ERR_EN is defined.
module tb_xy_route_demux;

`ifdef ROUTE_ERR_EN
    localparam int         TB_MESH_X = 3;
    localparam logic [7:0] EAST_HDR  = 8'hB2;
`else
    localparam int         TB_MESH_X = 4;
    localparam logic [7:0] EAST_HDR  = 8'hF2;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    xy_route_demux_if bus ();

    xy_route_demux #(
        .LOCAL_X    (2'd1),
        .LOCAL_Y    (2'd1),
        .MESH_X     (TB_MESH_X),
        .MESH_Y     (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] h);
        bus.in_valid = 1'b1;
        bus.in_data  = h;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.fifo_read = 5'b00000;
        cyc();
        cyc();
        checks++;
        if ({bus.in_ready, bus.write, bus.data_out, bus.busy, bus.route_err} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b wr=%b d=%h busy=%b err=%b exp all 0",
                     bus.in_ready, bus.write, bus.data_out, bus.busy, bus.route_err);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.credit_r[i] !== 4'd8) begin
                failures++;
                $display("FAIL reset_credit[%0d] got=%0d exp=8", i, dut.credit_r[i]);
            end
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_east_packet();
        send_hdr(EAST_HDR);
        checks++;
        if (bus.busy !== 1'b1 || bus.write !== 5'b00000) begin
            failures++;
            $display("FAIL east_route_cycle got busy=%b wr=%b exp busy=1 wr=00000", bus.busy, bus.write);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA1;
        cyc();
        checks++;
        if (bus.write !== 5'b00000 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL east_hdr_cycle got wr=%b rdy=%b exp wr=00000 rdy=0", bus.write, bus.in_ready);
        end
        cyc();
        checks++;
        if (bus.write !== 5'b00100 || bus.data_out !== EAST_HDR) begin
            failures++;
            $display("FAIL east_hdr_write got wr=%b d=%h exp wr=00100 d=%h", bus.write, bus.data_out, EAST_HDR);
        end
        cyc();
        bus.in_data = 8'hA2;
        checks++;
        if (bus.write !== 5'b00100 || bus.data_out !== 8'hA1) begin
            failures++;
            $display("FAIL east_body1 got wr=%b d=%h exp wr=00100 d=a1", bus.write, bus.data_out);
        end
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.write !== 5'b00100 || bus.data_out !== 8'hA2 || dut.credit_r[2] !== 4'd5) begin
            failures++;
            $display("FAIL east_body2 got wr=%b d=%h credit=%0d exp wr=00100 d=a2 credit=5",
                     bus.write, bus.data_out, dut.credit_r[2]);
        end
        cyc();
        checks++;
        if (bus.write !== 5'b00000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL east_done got wr=%b busy=%b exp wr=00000 busy=0", bus.write, bus.busy);
        end
    endtask

    task automatic test_local_zero_len();
        send_hdr(8'h50);
        cyc();
        cyc();
        checks++;
        if (bus.write !== 5'b00001 || bus.data_out !== 8'h50) begin
            failures++;
            $display("FAIL local_write got wr=%b d=%h exp wr=00001 d=50", bus.write, bus.data_out);
        end
        cyc();
        checks++;
        if (bus.write !== 5'b00000 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL local_idle got wr=%b busy=%b rdy=%b exp 00000/0/1", bus.write, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_routes();
        logic [7:0] hdrs [2];
        logic [4:0] exps [2];
        hdrs[0] = 8'h20; exps[0] = 5'b10000;
        hdrs[1] = 8'h70; exps[1] = 5'b01000;
        for (int k = 0; k < 2; k++) begin
            send_hdr(hdrs[k]);
            cyc();
            cyc();
            checks++;
            if (bus.write !== exps[k] || bus.data_out !== hdrs[k]) begin
                failures++;
                $display("FAIL route_%h got wr=%b d=%h exp wr=%b d=%h", hdrs[k], bus.write, bus.data_out, exps[k], hdrs[k]);
            end
            cyc();
        end
    endtask

    task automatic test_credit_exhaust();
        int  n_wr = 0;
        int  sent = 0;
        logic take;
        send_hdr(8'h48);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB0;
        for (int c = 0; c < 20; c++) begin
            take = bus.in_valid && bus.in_ready;
            cyc();
            if (bus.write == 5'b00010) n_wr++;
            if (take) begin
                sent++;
                bus.in_data = 8'hB0 + 8'(sent);
            end
        end
        checks++;
        if (n_wr != 8 || sent != 7 || bus.in_ready !== 1'b0 || dut.credit_r[1] !== 4'd0) begin
            failures++;
            $display("FAIL credit_stall got writes=%0d body=%0d rdy=%b credit=%0d exp 8/7/0/0",
                     n_wr, sent, bus.in_ready, dut.credit_r[1]);
        end
        bus.fifo_read = 5'b00010;
        cyc();
        bus.fifo_read = 5'b00000;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.write !== 5'b00000) begin
            failures++;
            $display("FAIL credit_return got rdy=%b wr=%b exp rdy=1 wr=00000", bus.in_ready, bus.write);
        end
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.write !== 5'b00010 || bus.data_out !== 8'hB7) begin
            failures++;
            $display("FAIL credit_ninth got wr=%b d=%h exp wr=00010 d=b7", bus.write, bus.data_out);
        end
        cyc();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL credit_done got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_credit_saturate();
        send_hdr(8'h50);
        cyc();
        bus.fifo_read = 5'b00001;
        cyc();
        bus.fifo_read = 5'b00000;
        checks++;
        if (bus.write !== 5'b00001 || dut.credit_r[0] !== 4'd7) begin
            failures++;
            $display("FAIL credit_cancel got wr=%b credit=%0d exp wr=00001 credit=7", bus.write, dut.credit_r[0]);
        end
        bus.fifo_read = 5'b11111;
        for (int c = 0; c < 11; c++) cyc();
        bus.fifo_read = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.credit_r[i] !== 4'd8) begin
                failures++;
                $display("FAIL credit_sat[%0d] got=%0d exp=8", i, dut.credit_r[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        send_hdr(8'hB3);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC1;
        cyc();
        cyc();
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.write !== 5'b00100 || bus.data_out !== 8'hC1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_body1 got wr=%b d=%h busy=%b exp wr=00100 d=c1 busy=1", bus.write, bus.data_out, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.write, bus.data_out, bus.busy, bus.route_err} !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset_outputs got rdy=%b wr=%b d=%h busy=%b exp all 0",
                     bus.in_ready, bus.write, bus.data_out, bus.busy);
        end
        checks++;
        if (dut.credit_r[2] !== 4'd8) begin
            failures++;
            $display("FAIL mid_reset_credit got=%0d exp=8", dut.credit_r[2]);
        end
        cyc();
        rst = 1'b0;
        cyc();
        send_hdr(8'h50);
        cyc();
        cyc();
        checks++;
        if (bus.write !== 5'b00001 || bus.data_out !== 8'h50) begin
            failures++;
            $display("FAIL post_reset_hdr got wr=%b d=%h exp wr=00001 d=50", bus.write, bus.data_out);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [7:0] flits [4];
        logic [4:0] got_w [4];
        logic [7:0] got_d [4];
        int         got_c [4];
        int         sent = 0;
        int         n = 0;
        logic       take;
        flits[0] = EAST_HDR; flits[1] = 8'hA1; flits[2] = 8'hA2; flits[3] = 8'h50;
        bus.in_valid = 1'b1;
        bus.in_data  = flits[0];
        for (int c = 0; c < 16; c++) begin
            take = bus.in_valid && bus.in_ready;
            cyc();
            if (bus.write != 5'b00000 && n < 4) begin
                got_w[n] = bus.write;
                got_d[n] = bus.data_out;
                got_c[n] = c;
                n++;
            end
            if (take) begin
                sent++;
                if (sent == 4) bus.in_valid = 1'b0;
                else bus.in_data = flits[sent];
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=4", n);
        end else begin
            checks++;
            if (got_w[2] !== 5'b00100 || got_d[2] !== 8'hA2 || got_w[3] !== 5'b00001 || got_d[3] !== 8'h50) begin
                failures++;
                $display("FAIL b2b_data got %b/%h %b/%h exp 00100/a2 00001/50", got_w[2], got_d[2], got_w[3], got_d[3]);
            end
            checks++;
            if (got_c[3] - got_c[2] != 3) begin
                failures++;
                $display("FAIL b2b_gap got=%0d exp=3", got_c[3] - got_c[2]);
            end
        end
    endtask

`ifdef ROUTE_ERR_EN
    task automatic test_route_err();
        send_hdr(8'hC1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD1;
        cyc();
        checks++;
        if (bus.route_err !== 1'b1 || bus.write !== 5'b00000 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drop_pulse got err=%b wr=%b rdy=%b exp 1/00000/1", bus.route_err, bus.write, bus.in_ready);
        end
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.route_err !== 1'b0 || bus.write !== 5'b00000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_done got err=%b wr=%b busy=%b exp 0/00000/0", bus.route_err, bus.write, bus.busy);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_east_packet();
        test_local_zero_len();
        test_routes();
        test_credit_exhaust();
        test_credit_saturate();
        test_reset_mid_packet();
        test_back_to_back();
`ifdef ROUTE_ERR_EN
        test_route_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
